// File: rtl/parity_serializer_pkg.sv
// Shared definitions for the parity serializer: FSM state encoding and the idle line level.
package parity_serializer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/parity_serializer_xor_tree.sv
// Combinational XOR reduction of a word, built as a chain of 2-input XOR gates.
module parity_xor_tree #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_data,
  output logic              o_parity
);

  // Each stage owns its own net so the chain stays a clean acyclic netlist.
  for (genvar i = 0; i < DATA_W; i++) begin : g_chain
    logic w_acc;
    if (i == 0) begin : g_first
      assign w_acc = i_data[0];
    end else begin : g_xor
      xor u_xor (w_acc, g_chain[i-1].w_acc, i_data[i]);
    end
  end

  assign o_parity = g_chain[DATA_W-1].w_acc;

endmodule

// File: rtl/parity_serializer.sv
// UART-style frame transmitter: start bit, data LSB-first, parity bit, stop bit,
// each held CLKS_PER_BIT cycles; word accepted through a valid/ready handshake.
module parity_serializer
  import parity_serializer_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(DATA_W - 1);

  state_t              r_state, w_state_nxt;
  logic [TICK_W-1:0]   r_tick, w_tick_nxt;
  logic [BIT_W-1:0]    r_bit_idx, w_bit_nxt;
  logic [DATA_W-1:0]   r_shreg, w_shreg_nxt;
  logic                r_parity, w_parity_nxt;
  logic                r_tx, w_tx_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                w_parity;
  logic                w_tick_last;

  parity_xor_tree #(.DATA_W(DATA_W)) u_parity (
    .i_data   (in_data),
    .o_parity (w_parity)
  );

  assign in_ready    = (r_state == IDLE) && rst_n;
  assign w_tick_last = (r_tick == TICK_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_tick    <= '0;
      r_bit_idx <= '0;
      r_shreg   <= '0;
      r_parity  <= 1'b0;
      r_tx      <= IDLE_LEVEL;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tick    <= w_tick_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shreg   <= w_shreg_nxt;
      r_parity  <= w_parity_nxt;
      r_tx      <= w_tx_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_tick_nxt   = r_tick;
    w_bit_nxt    = r_bit_idx;
    w_shreg_nxt  = r_shreg;
    w_parity_nxt = r_parity;
    case (r_state)
      IDLE: begin
        w_tick_nxt = '0;
        if (in_valid && in_ready) begin
          w_shreg_nxt  = in_data;
          w_parity_nxt = w_parity ^ PARITY_ODD;
          w_state_nxt  = START;
        end
      end
      START: begin
        w_tick_nxt = w_tick_last ? '0 : r_tick + TICK_W'(1);
        if (w_tick_last) begin
          w_bit_nxt   = '0;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        w_tick_nxt = w_tick_last ? '0 : r_tick + TICK_W'(1);
        if (w_tick_last) begin
          w_shreg_nxt = r_shreg >> 1;
          if (r_bit_idx == BIT_MAX) w_state_nxt = PARITY;
          else                      w_bit_nxt   = r_bit_idx + BIT_W'(1);
        end
      end
      PARITY: begin
        w_tick_nxt = w_tick_last ? '0 : r_tick + TICK_W'(1);
        if (w_tick_last) w_state_nxt = STOP;
      end
      STOP: begin
        w_tick_nxt = w_tick_last ? '0 : r_tick + TICK_W'(1);
        if (w_tick_last) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_tick_nxt  = '0;
      end
    endcase
  end

  // Outputs are decoded from next-state values so they appear registered with no extra lag.
  always_comb begin
    w_tx_nxt = IDLE_LEVEL;
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shreg_nxt[0];
      PARITY:  w_tx_nxt = w_parity_nxt;
      default: w_tx_nxt = IDLE_LEVEL;
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
    w_done_nxt = (w_state_nxt == STOP) && (w_tick_nxt == TICK_MAX);
  end

  assign tx_out     = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule

// File: tb/tb_parity_serializer.sv
// Directed bench for parity_serializer: three instances (even, odd, 1-bit/1-clock) checked
// cycle by cycle against a bit-level frame model through per-instance queues.
module tb_parity_serializer;

  typedef struct packed {
    logic tx;
    logic busy;
    logic done;
    logic rdy;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       rdy0, tx0, busy0, done0;
  logic       rdy1, tx1, busy1, done1;
  logic       rdye, txe, busye, donee;

  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  parity_serializer #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .tx_out(tx0), .busy(busy0), .frame_done(done0)
  );

  parity_serializer #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .tx_out(tx1), .busy(busy1), .frame_done(done1)
  );

  parity_serializer #(.DATA_W(1), .CLKS_PER_BIT(1), .PARITY_ODD(1'b0)) dut_e (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdye), .in_data(in_data[0:0]),
    .tx_out(txe), .busy(busye), .frame_done(donee)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int id, input logic [7:0] d, input int dw,
                            input int cpb, input bit odd);
    logic [10:0] bits;
    logic        par;
    exp_t        e;
    par = odd;
    bits = '0;
    bits[0] = 1'b0;
    for (int k = 0; k < dw; k++) begin
      bits[1+k] = d[k];
      par = par ^ d[k];
    end
    bits[dw+1] = par;
    bits[dw+2] = 1'b1;
    for (int b = 0; b < dw + 3; b++) begin
      for (int c = 0; c < cpb; c++) begin
        e.tx   = bits[b];
        e.busy = 1'b1;
        e.rdy  = 1'b0;
        e.done = (b == dw + 2) && (c == cpb - 1);
        case (id)
          0:       q0.push_back(e);
          1:       q1.push_back(e);
          default: q2.push_back(e);
        endcase
      end
    end
  endtask

  task automatic idle_check(input string tag);
    chk({tag, "_tx"},   tx0,   1'b1);
    chk({tag, "_busy"}, busy0, 1'b0);
    chk({tag, "_done"}, done0, 1'b0);
    chk({tag, "_rdy"},  rdy0,  1'b1);
    chk({tag, "_tx1"},  tx1,   1'b1);
    chk({tag, "_rdy1"}, rdy1,  1'b1);
  endtask

  // Called #1 after a rising edge with the instances idle; handshake happens on the next edge.
  task automatic run_frame(input logic [7:0] d, input bit bp, input bit chk_e,
                           input logic p0, input logic p1);
    exp_t e;
    int   n;
    in_data  = d;
    in_valid = 1'b1;
    chk("rdy_pre", rdy0, 1'b1);
    push_frame(0, d, 8, 4, 1'b0);
    push_frame(1, d, 8, 4, 1'b1);
    if (chk_e) push_frame(2, d, 1, 1, 1'b0);
    @(posedge clk); #1;
    if (!bp) in_valid = 1'b0;
    n = 1;
    while (q0.size() > 0 || q1.size() > 0 || q2.size() > 0) begin
      if (n > 200) begin
        chk("frame_timeout", 1'b1, 1'b0);
        q0.delete(); q1.delete(); q2.delete();
        break;
      end
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk($sformatf("tx0@%0d", n),   tx0,   e.tx);
        chk($sformatf("busy0@%0d", n), busy0, e.busy);
        chk($sformatf("done0@%0d", n), done0, e.done);
        chk($sformatf("rdy0@%0d", n),  rdy0,  e.rdy);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk($sformatf("tx1@%0d", n),   tx1,   e.tx);
        chk($sformatf("done1@%0d", n), done1, e.done);
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        chk($sformatf("txe@%0d", n),   txe,   e.tx);
        chk($sformatf("busye@%0d", n), busye, e.busy);
        chk($sformatf("donee@%0d", n), donee, e.done);
      end
      if (n == 37) begin
        chk("parity_even", tx0, p0);
        chk("parity_odd",  tx1, p1);
      end
      if (bp) in_data = 8'($urandom);
      @(posedge clk); #1;
      n++;
    end
    idle_check("post");
    if (chk_e) begin
      chk("post_txe",   txe,   1'b1);
      chk("post_busye", busye, 1'b0);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset held for three cycles, then idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx",   tx0,   1'b1);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_rdy",  rdy0,  1'b0);
    chk("rst_rdye", rdye,  1'b0);
    rst_n = 1'b1;
    #1;
    chk("rel_rdy", rdy0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      idle_check("idle");
    end

    // Even/odd parity frames
    run_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(8'h07, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-pressure: valid held, data scrambled mid-frame; next word taken at T+45
    run_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1);
    run_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset during data bit 3 of an A5 frame
    in_data  = 8'hA5;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    chk("mid_bit3", tx0,   1'b0);
    chk("mid_busy", busy0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rdy_low", rdy0, 1'b0);
    @(posedge clk); #1;
    chk("mrst_tx",   tx0,   1'b1);
    chk("mrst_busy", busy0, 1'b0);
    chk("mrst_done", done0, 1'b0);
    chk("mrst_rdy",  rdy0,  1'b0);
    @(posedge clk); #1;
    chk("mrst_done2", done0, 1'b0);
    rst_n = 1'b1;
    #1;
    run_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);

    // 1-bit word at one clock per bit
    run_frame(8'h01, 1'b0, 1'b1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
